// File: rtl/watch_pkg.sv
// Shared encodings and field geometry for the watch datapath.
package watch_pkg;

   typedef enum logic [1:0] {
      ADJ_NONE = 2'd0,
      ADJ_SEC  = 2'd1,
      ADJ_MIN  = 2'd2,
      ADJ_HOUR = 2'd3
   } adj_sel_e;

   localparam int SEC_MAX = 60;
   localparam int MIN_MAX = 60;

   localparam int SEC_W  = 6;
   localparam int MIN_W  = 6;
   localparam int HOUR_W = 5;

endpackage

// File: rtl/wrap_counter_ud.sv
// Modulo-MOD field counter: clear to preset, up/down adjust, carry-driven increment.
module wrap_counter_ud #(
   parameter int MOD = 60,
   parameter int W   = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] i_init,
   input  logic         i_clr,
   input  logic         i_carry_in,
   input  logic         i_up,
   input  logic         i_dn,
   output logic [W-1:0] o_count,
   output logic         o_carry_out
);

   localparam logic [W-1:0] LAST = W'(MOD - 1);

   logic at_last;
   logic at_zero;

   assign at_last = (o_count == LAST);
   assign at_zero = (o_count == '0);

   // An adjusted field swallows the incoming carry, so it must not pass one on.
   assign o_carry_out = i_carry_in & at_last & ~(i_up | i_dn);

   always_ff @(posedge clk) begin
      if (rst) begin
         o_count <= i_init;
      end else if (i_clr) begin
         o_count <= i_init;
      end else if (i_up) begin
         o_count <= at_last ? '0 : o_count + W'(1);
      end else if (i_dn) begin
         o_count <= at_zero ? LAST : o_count - W'(1);
      end else if (i_carry_in) begin
         o_count <= at_last ? '0 : o_count + W'(1);
      end
   end

endmodule

// File: rtl/watch_dp_param.sv
// Watch datapath: clock prescaler plus cascaded sub-second/sec/min/hour counters.
module watch_dp_param
   import watch_pkg::*;
#(
   parameter int CLK_FREQ  = 100_000_000,
   parameter int TICK_HZ   = 100,
   parameter int HOUR_MAX  = 24,
   parameter int HOUR_INIT = 12,
   parameter int SS_W      = $clog2(TICK_HZ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_run,
   input  logic              i_clear,
   input  logic [1:0]        i_adj_sel,
   input  logic              i_adj_up,
   input  logic              i_adj_dn,
   input  logic              i_mode12,
   output logic [SS_W-1:0]   o_msec,
   output logic [SEC_W-1:0]  o_sec,
   output logic [MIN_W-1:0]  o_min,
   output logic [HOUR_W-1:0] o_hour,
   output logic [HOUR_W-1:0] o_hour_disp,
   output logic              o_pm,
   output logic              o_day_tick
);

   localparam int PRE_DIV = CLK_FREQ / TICK_HZ;
   localparam int PRE_W   = (PRE_DIV > 1) ? $clog2(PRE_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRE_DIV - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic             tick;
   logic             adj_up;
   logic             adj_dn;
   logic             sec_up, sec_dn, min_up, min_dn, hour_up, hour_dn;
   logic             sec_adj;
   logic             msec_co, sec_co, min_co, hour_co;

   // Simultaneous up and down cancel out and count as no adjust at all.
   assign adj_up  = i_adj_up & ~i_adj_dn;
   assign adj_dn  = i_adj_dn & ~i_adj_up;
   assign sec_up  = adj_up & (i_adj_sel == ADJ_SEC);
   assign sec_dn  = adj_dn & (i_adj_sel == ADJ_SEC);
   assign min_up  = adj_up & (i_adj_sel == ADJ_MIN);
   assign min_dn  = adj_dn & (i_adj_sel == ADJ_MIN);
   assign hour_up = adj_up & (i_adj_sel == ADJ_HOUR);
   assign hour_dn = adj_dn & (i_adj_sel == ADJ_HOUR);
   assign sec_adj = sec_up | sec_dn;

   // Down-counter reloaded with PRE_DIV-1; the terminal count at zero is the tick.
   assign tick = i_run & (pre_cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= PRE_LAST;
      end else if (i_clear || sec_adj) begin
         pre_cnt <= PRE_LAST;
      end else if (i_run) begin
         pre_cnt <= tick ? PRE_LAST : pre_cnt - PRE_W'(1);
      end
   end

   wrap_counter_ud #(.MOD(TICK_HZ), .W(SS_W)) u_msec (
      .clk(clk), .rst(rst), .i_init('0), .i_clr(i_clear | sec_adj),
      .i_carry_in(tick), .i_up(1'b0), .i_dn(1'b0),
      .o_count(o_msec), .o_carry_out(msec_co)
   );

   wrap_counter_ud #(.MOD(SEC_MAX), .W(SEC_W)) u_sec (
      .clk(clk), .rst(rst), .i_init('0), .i_clr(i_clear),
      .i_carry_in(msec_co), .i_up(sec_up), .i_dn(sec_dn),
      .o_count(o_sec), .o_carry_out(sec_co)
   );

   wrap_counter_ud #(.MOD(MIN_MAX), .W(MIN_W)) u_min (
      .clk(clk), .rst(rst), .i_init('0), .i_clr(i_clear),
      .i_carry_in(sec_co), .i_up(min_up), .i_dn(min_dn),
      .o_count(o_min), .o_carry_out(min_co)
   );

   wrap_counter_ud #(.MOD(HOUR_MAX), .W(HOUR_W)) u_hour (
      .clk(clk), .rst(rst), .i_init(HOUR_W'(HOUR_INIT)), .i_clr(i_clear),
      .i_carry_in(min_co), .i_up(hour_up), .i_dn(hour_dn),
      .o_count(o_hour), .o_carry_out(hour_co)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         o_day_tick <= 1'b0;
      end else begin
         o_day_tick <= hour_co & ~i_clear;
      end
   end

   always_comb begin
      o_hour_disp = o_hour;
      if ((HOUR_MAX == 24) && i_mode12) begin
         if (o_hour == '0) begin
            o_hour_disp = HOUR_W'(12);
         end else if (o_hour > HOUR_W'(12)) begin
            o_hour_disp = o_hour - HOUR_W'(12);
         end
      end
   end

   assign o_pm = (o_hour >= HOUR_W'(12));

endmodule

// File: tb/tb_watch_dp_param.sv
// Directed bench for watch_dp_param at CLK_FREQ=1000, TICK_HZ=100 (tick every 10 clk).
module tb_watch_dp_param;

   logic       clk;
   logic       rst;
   logic       i_run;
   logic       i_clear;
   logic [1:0] i_adj_sel;
   logic       i_adj_up;
   logic       i_adj_dn;
   logic       i_mode12;
   logic [6:0] o_msec;
   logic [5:0] o_sec;
   logic [5:0] o_min;
   logic [4:0] o_hour;
   logic [4:0] o_hour_disp;
   logic       o_pm;
   logic       o_day_tick;

   int checks   = 0;
   int failures = 0;

   watch_dp_param #(
      .CLK_FREQ(1000), .TICK_HZ(100), .HOUR_MAX(24), .HOUR_INIT(12), .SS_W(7)
   ) dut (
      .clk(clk), .rst(rst), .i_run(i_run), .i_clear(i_clear),
      .i_adj_sel(i_adj_sel), .i_adj_up(i_adj_up), .i_adj_dn(i_adj_dn),
      .i_mode12(i_mode12), .o_msec(o_msec), .o_sec(o_sec), .o_min(o_min),
      .o_hour(o_hour), .o_hour_disp(o_hour_disp), .o_pm(o_pm),
      .o_day_tick(o_day_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic adj(input logic [1:0] sel, input logic up, input logic dn, input int times);
      for (int k = 0; k < times; k++) begin
         i_adj_sel = sel;
         i_adj_up  = up;
         i_adj_dn  = dn;
         step(1);
         i_adj_up  = 1'b0;
         i_adj_dn  = 1'b0;
         i_adj_sel = 2'd0;
      end
   endtask

   task automatic chk_time(input string tag, input int h, input int m, input int s, input int ms);
      chk({tag, "_hour"}, 32'(o_hour), 32'(h));
      chk({tag, "_min"},  32'(o_min),  32'(m));
      chk({tag, "_sec"},  32'(o_sec),  32'(s));
      chk({tag, "_msec"}, 32'(o_msec), 32'(ms));
   endtask

   initial begin
      rst = 1'b1; i_run = 1'b0; i_clear = 1'b0; i_adj_sel = 2'd0;
      i_adj_up = 1'b0; i_adj_dn = 1'b0; i_mode12 = 1'b1;
      step(2);
      rst = 1'b0;
      chk_time("reset", 12, 0, 0, 0);
      chk("reset_disp", 32'(o_hour_disp), 32'd12);
      chk("reset_pm", 32'(o_pm), 32'd1);
      chk("reset_day", 32'(o_day_tick), 32'd0);

      i_run = 1'b1;
      step(1000);
      chk_time("run1000", 12, 0, 1, 0);
      i_run = 1'b0;
      step(50);
      chk_time("hold50", 12, 0, 1, 0);

      adj(2'd2, 1'b0, 1'b1, 1);
      chk_time("min_dn_wrap", 12, 59, 1, 0);
      adj(2'd1, 1'b0, 1'b1, 2);
      chk("sec_dn_wrap", 32'(o_sec), 32'd59);
      adj(2'd3, 1'b1, 1'b0, 11);
      chk_time("set_235959", 23, 59, 59, 0);
      chk("h23_disp", 32'(o_hour_disp), 32'd11);
      chk("h23_pm", 32'(o_pm), 32'd1);

      i_run = 1'b1;
      step(990);
      chk_time("pre_roll", 23, 59, 59, 99);
      step(9);
      chk_time("pre_roll_hold", 23, 59, 59, 99);
      chk("pre_roll_day", 32'(o_day_tick), 32'd0);
      step(1);
      chk_time("rollover", 0, 0, 0, 0);
      chk("roll_day", 32'(o_day_tick), 32'd1);
      chk("h0_disp", 32'(o_hour_disp), 32'd12);
      chk("h0_pm", 32'(o_pm), 32'd0);
      step(1);
      chk("roll_day_off", 32'(o_day_tick), 32'd0);
      i_run = 1'b0;

      adj(2'd1, 1'b1, 1'b0, 30);
      i_run = 1'b1;
      step(570);
      i_run = 1'b0;
      chk_time("sec30_ms57", 0, 0, 30, 57);
      adj(2'd1, 1'b1, 1'b0, 1);
      chk_time("sec_up_clr_ms", 0, 0, 31, 0);

      adj(2'd2, 1'b1, 1'b1, 1);
      chk("both_strobes", 32'(o_min), 32'd0);
      adj(2'd0, 1'b1, 1'b0, 1);
      chk_time("sel_none", 0, 0, 31, 0);

      adj(2'd1, 1'b1, 1'b0, 28);
      i_run = 1'b1;
      step(999);
      chk_time("coll_pre", 0, 0, 59, 99);
      i_adj_sel = 2'd1;
      i_adj_up  = 1'b1;
      step(1);
      i_adj_up  = 1'b0;
      i_adj_sel = 2'd0;
      i_run     = 1'b0;
      chk_time("collision", 0, 0, 0, 0);

      adj(2'd3, 1'b1, 1'b0, 13);
      chk("h13_disp", 32'(o_hour_disp), 32'd1);
      chk("h13_pm", 32'(o_pm), 32'd1);
      adj(2'd3, 1'b1, 1'b0, 10);
      chk("h23b_disp", 32'(o_hour_disp), 32'd11);
      i_mode12 = 1'b0;
      #1;
      chk("h23_raw", 32'(o_hour_disp), 32'd23);
      i_mode12 = 1'b1;
      adj(2'd3, 1'b1, 1'b0, 1);
      chk("hour_up_wrap", 32'(o_hour), 32'd0);
      chk("adj_no_day", 32'(o_day_tick), 32'd0);
      adj(2'd3, 1'b0, 1'b1, 1);
      chk("hour_dn_wrap", 32'(o_hour), 32'd23);

      i_run = 1'b1;
      step(37);
      chk("clr_pre_msec", 32'(o_msec), 32'd3);
      i_clear = 1'b1;
      step(1);
      i_clear = 1'b0;
      chk_time("clear", 12, 0, 0, 0);
      step(9);
      chk("clr_pre_zero", 32'(o_msec), 32'd0);
      step(1);
      chk("clr_pre_tick", 32'(o_msec), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
